serial_divider: RTL and testbench
=================================

Name: serial_divider

Overview:
- Iterative unsigned restoring divider: the inverse operation of the ripple adder/subtractor datapath.
- Computes quotient and remainder of in1 / in2 over WIDTH clock cycles, one quotient bit per cycle.
- Each cycle performs one trial subtraction on a ripple full-adder chain: B inverted, carry-in = 1.
- Sits beside the adder blocks as the arithmetic unit's division slice; driven by a start/done handshake.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on clk rise only when the FSM is in IDLE or DONE.
- in1  input  WIDTH  dividend; sampled with an accepted start.
- in2  input  WIDTH  divisor; sampled with an accepted start.
- quotient  output  WIDTH  registered quotient; held until the next DONE.
- remainder  output  WIDTH  registered remainder; held until the next DONE.
- busy  output  1  high throughout RUN.
- done  output  1  one-cycle pulse when results update.
- divzero  output  1  registered with the results; 1 when the captured divisor was 0.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE; quotient=0, remainder=0, busy=0, done=0, divzero=0; internal registers cleared. Release is synchronous to the next clk rise.
- Reset asserted mid-RUN aborts the operation with no done pulse and no result update.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> load operands, RUN.
  - RUN: iterates; leaves for DONE after exactly WIDTH cycles.
  - DONE: done=1 for one cycle; start=1 -> load, RUN (back-to-back); else -> IDLE.
- Operand load on accept: dvd<=in1; dvs<=in2; rem<=0 (WIDTH+1 bits); cnt<=WIDTH-1; divzero_next<=(in2==0).
- One RUN iteration:
  - t = {rem[WIDTH-1:0], dvd[WIDTH-1]} - {1'b0, dvs}, computed as a WIDTH+1 ripple sum with inverted B and cin=1.
  - Carry-out 1 (no borrow): rem<=t, shift 1 into dvd LSB.
  - Carry-out 0 (borrow): rem<={rem[WIDTH-1:0], dvd[WIDTH-1]}, shift 0 into dvd LSB.
  - dvd shifts left each cycle and becomes the quotient. cnt decrements; the cnt==0 iteration is the last.
- On the last RUN edge, the same edge that enters DONE: quotient<=final dvd, remainder<=rem[WIDTH-1:0], divzero<=divzero_next.
- Latency: start accepted at edge k -> RUN edges k+1..k+WIDTH -> done high during the cycle after edge k+WIDTH.
- busy is a registered decode of state==RUN: 1 from edge k+1 through edge k+WIDTH.
- Divide by zero: no special path. Every trial succeeds, so quotient=all ones and remainder=dividend, with divzero=1 and the same latency.
- Invariant on every valid result: quotient*in2 + remainder == in1 and remainder < in2, for in2 != 0.
- start during RUN: ignored; operands not resampled, the in-flight result is unaffected.
- start and in1/in2 are ignored in every cycle not sampled in IDLE or DONE.
- Outputs never glitch outside the DONE update edge.

Test Plan:
- WIDTH=4, in1=13, in2=4, start for one cycle from IDLE -> busy high for 4 cycles; done in the 5th cycle after the start edge; quotient=3, remainder=1, divzero=0.
- in1=15, in2=1 -> quotient=15, remainder=0. Then in1=7, in2=9 -> quotient=0, remainder=7.
- in1=11, in2=0 -> quotient=15, remainder=11, divzero=1, same latency. A following 6/3 clears divzero with quotient=2, remainder=0.
- start pulsed with in1=1, in2=1 on the 2nd RUN cycle of an active 14/3 -> one done only; quotient=4, remainder=2; no second operation.
- start held high continuously with 9/2 then 8/8 applied on the accepting edges:
  - done pulses 5 cycles apart (DONE->RUN back-to-back, no IDLE cycle).
  - Results: (4,1) then (1,0).
- rstn driven low asynchronously mid-RUN, between clock edges -> all outputs 0 immediately, no done pulse. After release, 12/5 -> quotient=2, remainder=2.
- Exhaustive sweep, WIDTH=4, all 256 operand pairs against the reference model; also WIDTH=8 random pairs -> invariant holds; latency always WIDTH+1 cycles.

Source files
------------

// File: rtl/serial_divider_if.sv
// Operand/result bundle for the serial divider: start with operands in, registered results out.
// The master drives start/in1/in2; the slave (divider) owns the result registers and status flags.
interface serial_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             divzero;

  modport master (
    output start, in1, in2,
    input  quotient, remainder, busy, done, divzero
  );

  modport slave (
    input  start, in1, in2,
    output quotient, remainder, busy, done, divzero
  );
endinterface

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle via a ripple trial subtractor.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy (accepted in IDLE/DONE only).
module serial_divider #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  serial_divider_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             load, last;

  logic [WIDTH-1:0] dvd_q, dvs_q;
  // Partial remainder stays below the divisor, so its extra top bit is always zero and not stored.
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             divzero_nxt_q;

  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             busy_q, done_q, divzero_q;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] dvd_shift;
  logic [WIDTH-1:0] rem_next;

  // a - b as a ripple full-adder chain: b inverted, carry-in 1; returns {carry_out, sum[WIDTH-1:0]}.
  function automatic logic [WIDTH:0] ripple_sub(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic             c;
    logic             bn;
    logic [WIDTH-1:0] s;
    c = 1'b1;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bn   = ~b[i];
      s[i] = a[i] ^ bn ^ c;
      c    = (a[i] & bn) | (a[i] & c) | (bn & c);
    end
    bn = ~b[WIDTH];
    c  = (a[WIDTH] & bn) | (a[WIDTH] & c) | (bn & c);
    return {c, s};
  endfunction

  always_comb begin
    trial_a   = {rem_q, dvd_q[WIDTH-1]};
    trial     = ripple_sub(trial_a, {1'b0, dvs_q});
    no_borrow = trial[WIDTH];
    dvd_shift = {dvd_q[WIDTH-2:0], no_borrow};
    rem_next  = no_borrow ? trial[WIDTH-1:0] : trial_a[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          last    = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      divzero_nxt_q <= 1'b0;
    end else if (load) begin
      dvd_q         <= bus.in1;
      dvs_q         <= bus.in2;
      rem_q         <= '0;
      cnt_q         <= CW'(WIDTH - 1);
      divzero_nxt_q <= (bus.in2 == '0);
    end else if (state_q == RUN) begin
      dvd_q <= dvd_shift;
      rem_q <= rem_next;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Results only move on the final iteration edge, which is also the edge entering DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      divzero_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (last) begin
        quotient_q  <= dvd_shift;
        remainder_q <= rem_next;
        divzero_q   <= divzero_nxt_q;
      end
      busy_q <= (state_d == RUN);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.divzero   = divzero_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_divider.sv
// Directed bench for serial_divider at WIDTH=4 (hand vectors, sweep) and WIDTH=8 (random pairs).
module tb_serial_divider;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  serial_divider_if #(.WIDTH(4)) bus4 ();
  serial_divider_if #(.WIDTH(8)) bus8 ();

  serial_divider #(.WIDTH(4)) dut4 (.clk(clk), .rstn(rstn), .bus(bus4));
  serial_divider #(.WIDTH(8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called mid-cycle 1 after the accepting edge; returns the cycle in which done is seen.
  task automatic wait4(output int cyc, output int nbusy);
    cyc   = 1;
    nbusy = 0;
    while (bus4.done !== 1'b1 && cyc < 20) begin
      if (bus4.busy === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait8(output int cyc, output int nbusy);
    cyc   = 1;
    nbusy = 0;
    while (bus8.done !== 1'b1 && cyc < 30) begin
      if (bus8.busy === 1'b1) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                     input int eq, input int er, input int ez);
    int cyc, nb;
    bus4.start = 1'b1;
    bus4.in1   = a;
    bus4.in2   = b;
    @(negedge clk);
    bus4.start = 1'b0;
    wait4(cyc, nb);
    check({tag, "_lat"},  cyc, 5);
    check({tag, "_busy"}, nb, 4);
    check({tag, "_q"},    32'(bus4.quotient), eq);
    check({tag, "_r"},    32'(bus4.remainder), er);
    check({tag, "_dz"},   32'(bus4.divzero), ez);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus4.done), 0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int cyc, nb;
    int eq, er;
    eq = (b == 0) ? 255 : int'(a) / int'(b);
    er = (b == 0) ? int'(a) : int'(a) % int'(b);
    bus8.start = 1'b1;
    bus8.in1   = a;
    bus8.in2   = b;
    @(negedge clk);
    bus8.start = 1'b0;
    wait8(cyc, nb);
    check("w8_lat", cyc, 9);
    check("w8_q", 32'(bus8.quotient), eq);
    check("w8_r", 32'(bus8.remainder), er);
    check("w8_dz", 32'(bus8.divzero), (b == 0) ? 1 : 0);
    if (b != 0) begin
      check("w8_inv", 32'(int'(bus8.quotient) * int'(b) + int'(bus8.remainder)), 32'(a));
      check("w8_rlt", 32'(int'(bus8.remainder) < int'(b)), 1);
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc, nb, ndone;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    bus4.start = 1'b0; bus4.in1 = '0; bus4.in2 = '0;
    bus8.start = 1'b0; bus8.in1 = '0; bus8.in2 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_q",    32'(bus4.quotient), 0);
    check("rst_r",    32'(bus4.remainder), 0);
    check("rst_busy", 32'(bus4.busy), 0);
    check("rst_done", 32'(bus4.done), 0);
    check("rst_dz",   32'(bus4.divzero), 0);
    check("rst_q8",   32'(bus8.quotient), 0);
    rstn = 1'b1;
    @(negedge clk);

    op4("d13_4", 4'd13, 4'd4, 3, 1, 0);
    op4("d15_1", 4'd15, 4'd1, 15, 0, 0);
    op4("d7_9",  4'd7,  4'd9, 0, 7, 0);
    op4("d11_0", 4'd11, 4'd0, 15, 11, 1);
    op4("d6_3",  4'd6,  4'd3, 2, 0, 0);

    // start re-pulsed with 1/1 on the second RUN cycle of 14/3
    bus4.start = 1'b1; bus4.in1 = 4'd14; bus4.in2 = 4'd3;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    bus4.start = 1'b1; bus4.in1 = 4'd1; bus4.in2 = 4'd1;
    @(negedge clk);
    bus4.start = 1'b0; bus4.in1 = 4'd0; bus4.in2 = 4'd0;
    cyc = 3;
    while (bus4.done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_lat", cyc, 5);
    check("ign_q", 32'(bus4.quotient), 4);
    check("ign_r", 32'(bus4.remainder), 2);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) ndone++;
    end
    check("ign_extra_done", ndone, 0);
    check("ign_idle_busy", 32'(bus4.busy), 0);

    // start held high: 9/2 then 8/8 back to back
    bus4.start = 1'b1; bus4.in1 = 4'd9; bus4.in2 = 4'd2;
    @(negedge clk);
    wait4(cyc, nb);
    check("b2b_lat1", cyc, 5);
    check("b2b_q1", 32'(bus4.quotient), 4);
    check("b2b_r1", 32'(bus4.remainder), 1);
    bus4.in1 = 4'd8; bus4.in2 = 4'd8;
    @(negedge clk);
    check("b2b_busy_next", 32'(bus4.busy), 1);
    wait4(cyc, nb);
    bus4.start = 1'b0;
    check("b2b_gap", cyc, 5);
    check("b2b_q2", 32'(bus4.quotient), 1);
    check("b2b_r2", 32'(bus4.remainder), 0);
    @(negedge clk);
    check("b2b_end_done", 32'(bus4.done), 0);
    check("b2b_end_busy", 32'(bus4.busy), 0);

    // asynchronous reset in the middle of a 13/4 run
    bus4.start = 1'b1; bus4.in1 = 4'd13; bus4.in2 = 4'd4;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    check("ar_busy_before", 32'(bus4.busy), 1);
    #2 rstn = 1'b0;
    #1;
    check("ar_q",    32'(bus4.quotient), 0);
    check("ar_r",    32'(bus4.remainder), 0);
    check("ar_busy", 32'(bus4.busy), 0);
    check("ar_done", 32'(bus4.done), 0);
    check("ar_dz",   32'(bus4.divzero), 0);
    @(negedge clk);
    rstn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) ndone++;
    end
    check("ar_no_activity", ndone, 0);
    op4("ar_12_5", 4'd12, 4'd5, 2, 2, 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        op4("sweep", 4'(a), 4'(b), (b == 0) ? 15 : a / b, (b == 0) ? a : a % b, (b == 0) ? 1 : 0);
      end
    end

    op8(8'd255, 8'd1);
    op8(8'd200, 8'd0);
    op8(8'd0, 8'd255);
    op8(8'd254, 8'd255);
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom_range(255)), 8'($urandom_range(255, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
